// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB passes through with priority, aux writes
// are buffered in a small FIFO and drained in idle WB slots.
module rf_wport_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_aux_valid,
    output logic        o_aux_ready,
    input  logic [4:0]  i_aux_rd,
    input  logic [31:0] i_aux_data,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_rd,
    output logic [31:0] o_rf_data,
    output logic        o_stall_req,
    output logic [31:0] o_pend_mask,
    output logic        o_aux_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_q;
    logic          drop_q;

    logic          empty;
    logic          full;
    logic          wb_hit;
    logic          pop;
    logic          accept;
    logic          push;
    logic [31:0]   pend_mask;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign wb_hit = i_wb_we && (i_wb_rd != 5'd0);
    assign pop    = !wb_hit && !empty;
    assign accept = i_aux_valid && !full;
    assign push   = accept && (i_aux_rd != 5'd0);

    // FIFO storage, pointers, occupancy, starvation counter and drop pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wait_q <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= accept && (i_aux_rd == 5'd0);
            if (push) begin
                rd_mem[wr_ptr]   <= i_aux_rd;
                data_mem[wr_ptr] <= i_aux_data;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (empty || pop) begin
                wait_q <= '0;
            end else if (wait_q != WW'(MAX_WAIT)) begin
                wait_q <= wait_q + WW'(1);
            end
        end
    end

    // Pending-destination mask over the occupied FIFO slots
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (CW'(i) < count) begin
                pend_mask[rd_mem[rd_ptr + AW'(i)]] = 1'b1;
            end
        end
    end

    // Write-port mux and status outputs, all forced low while reset is held
    always_comb begin
        o_rf_we     = 1'b0;
        o_rf_rd     = '0;
        o_rf_data   = '0;
        o_aux_ready = 1'b0;
        o_stall_req = 1'b0;
        o_pend_mask = '0;
        o_aux_drop  = 1'b0;
        if (i_rst_n) begin
            if (wb_hit) begin
                o_rf_we   = 1'b1;
                o_rf_rd   = i_wb_rd;
                o_rf_data = i_wb_data;
            end else if (!empty) begin
                o_rf_we   = 1'b1;
                o_rf_rd   = rd_mem[rd_ptr];
                o_rf_data = data_mem[rd_ptr];
            end
            o_aux_ready = !full;
            o_stall_req = (wait_q == WW'(MAX_WAIT));
            o_pend_mask = pend_mask;
            o_aux_drop  = drop_q;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_rf_wport_arbiter;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_WAIT = 8;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ready;
        logic        stall;
        logic [31:0] mask;
        logic        drop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        aux_valid = 1'b0;
    logic        aux_ready;
    logic [4:0]  aux_rd = '0;
    logic [31:0] aux_data = '0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [31:0] pend_mask;
    logic        aux_drop;

    int errors = 0;
    int checks = 0;

    ent_t mq[$];
    exp_t expq[$];
    int   m_wait = 0;
    bit   m_drop = 1'b0;

    rf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_aux_valid(aux_valid), .o_aux_ready(aux_ready),
        .i_aux_rd(aux_rd), .i_aux_data(aux_data),
        .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_data(rf_data),
        .o_stall_req(stall_req), .o_pend_mask(pend_mask), .o_aux_drop(aux_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict that cycle's outputs, advance the model
    task automatic step(input bit we, input logic [4:0] wrd, input logic [31:0] wdat,
                        input bit av, input logic [4:0] ard, input logic [31:0] adat);
        exp_t e;
        bit   hit;
        bit   acc;
        int   sz;
        @(posedge clk);
        #1;
        wb_we = we; wb_rd = wrd; wb_data = wdat;
        aux_valid = av; aux_rd = ard; aux_data = adat;
        hit = we && (wrd != 0);
        sz  = mq.size();
        e.we = hit || (sz > 0);
        e.rd = hit ? wrd : (sz > 0 ? mq[0].rd : 5'd0);
        e.data = hit ? wdat : (sz > 0 ? mq[0].data : 32'd0);
        e.ready = (sz < int'(DEPTH));
        e.stall = (m_wait == int'(MAX_WAIT));
        e.mask = '0;
        foreach (mq[i]) e.mask[mq[i].rd] = 1'b1;
        e.drop = m_drop;
        expq.push_back(e);
        acc = av && (sz < int'(DEPTH));
        m_drop = acc && (ard == 0);
        if (sz == 0 || !hit) m_wait = 0;
        else if (m_wait < int'(MAX_WAIT)) m_wait++;
        if (!hit && sz > 0) void'(mq.pop_front());
        if (acc && ard != 0) mq.push_back('{ard, adat});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic chk_forced(input string tag);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_rf_rd"}, 32'(rf_rd), 32'd0);
        chk({tag, "_rf_data"}, rf_data, 32'd0);
        chk({tag, "_ready"}, 32'(aux_ready), 32'd0);
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_mask"}, pend_mask, 32'd0);
        chk({tag, "_drop"}, 32'(aux_drop), 32'd0);
    endtask

    // Monitor: compare every predicted cycle against the DUT away from the edge
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e.we));
            chk("rf_rd", 32'(rf_rd), 32'(e.rd));
            chk("rf_data", rf_data, e.data);
            chk("aux_ready", 32'(aux_ready), 32'(e.ready));
            chk("stall_req", 32'(stall_req), 32'(e.stall));
            chk("pend_mask", pend_mask, e.mask);
            chk("aux_drop", 32'(aux_drop), 32'(e.drop));
        end
    end

    initial begin
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678; aux_valid = 1'b1;
        #3;
        chk_forced("reset0");
        #10;
        wb_we = 1'b0; aux_valid = 1'b0;
        rst_n = 1'b1;

        // Single aux write in idle WB
        step(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEAD_BEEF);
        idle(3);

        // WB busy starves a queued aux entry until stall, then drain
        step(1, 5'd3, 32'h0000_0033, 1, 5'd7, 32'h0000_0777);
        for (int i = 0; i < 11; i++) step(1, 5'd3, 32'(i), 0, 5'd0, 32'd0);
        idle(3);

        // Fill to full under busy WB, fifth request held back, then drain in order
        for (int i = 0; i < 5; i++) step(1, 5'd3, 32'hA0 + 32'(i), 1, 5'(10 + i), 32'hB0 + 32'(i));
        step(1, 5'd3, 32'hA5, 1, 5'd14, 32'hB4);
        for (int i = 0; i < 6; i++) step(0, 5'd0, 32'd0, 1, 5'd14, 32'hB4);
        idle(3);

        // Aux write to x0 is discarded; WB write to x0 is an idle slot
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF);
        step(1, 5'd0, 32'h5555_5555, 0, 5'd0, 32'd0);
        idle(2);

        // Duplicate destinations keep the mask bit until the last one drains
        step(1, 5'd2, 32'd1, 1, 5'd9, 32'h9_0001);
        step(1, 5'd2, 32'd2, 1, 5'd9, 32'h9_0002);
        step(1, 5'd2, 32'd3, 1, 5'd4, 32'h4_0001);
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit we;
            bit av;
            logic [4:0] ard;
            we  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 40 : 85));
            av  = ($urandom_range(0, 99) < 55);
            ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(we, 5'($urandom_range(0, 31)), $urandom, av, ard, $urandom);
        end
        idle(8);

        // Reset with three entries buffered: outputs drop at once, state is lost
        for (int i = 0; i < 3; i++) step(1, 5'd3, 32'd0, 1, 5'(20 + i), 32'hC0 + 32'(i));
        @(negedge clk);
        #2;
        wb_we = 1'b1; wb_rd = 5'd3; aux_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_forced("reset_mid");
        @(negedge clk);
        wb_we = 1'b0;
        rst_n = 1'b1;
        mq.delete();
        m_wait = 0;
        m_drop = 1'b0;
        idle(3);
        step(0, 5'd0, 32'd0, 1, 5'd6, 32'h6666_6666);
        idle(3);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
